// File: rtl/i281_code_loader_pkg.sv
// Shared i281 loader definitions: FSM state encoding and stream framing constants.
package i281_code_loader_pkg;

  localparam int BYTES_PER_WORD = 2;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_HI    = 3'd1;
  localparam state_t S_LO    = 3'd2;
  localparam state_t S_WRITE = 3'd3;
  localparam state_t S_CSUM  = 3'd4;
  localparam state_t S_FIN   = 3'd5;

endpackage

// File: rtl/i281_code_loader_if.sv
// Host byte stream plus code-memory write port; the loader sits on the master side.
interface i281_code_loader_if #(
  parameter int AW = 4
) ();

  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;

  modport master (
    input  in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/i281_byte_checksum.sv
// 8-bit wrapping byte accumulator with clear, accumulate and compare.
module i281_byte_checksum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       add,
  input  logic [7:0] din,
  input  logic [7:0] cmp,
  output logic       match
);

  logic [7:0] acc;

  always_ff @(posedge clk) begin
    if (!rst_n)   acc <= '0;
    else if (clr) acc <= '0;
    else if (add) acc <= acc + din;
  end

  assign match = (acc == cmp);

endmodule

// File: rtl/i281_code_loader.sv
// Loads WORDS 16-bit words from a byte stream (high byte first) into code memory,
// then verifies a trailing mod-256 checksum byte while holding the CPU.
//
// state   | meaning
// IDLE    | waiting for start, CPU released
// HI      | accepting high byte of current word
// LO      | accepting low byte of current word
// WRITE   | one-cycle memory write strobe
// CSUM    | accepting checksum byte
// FIN     | latch done/err result
module i281_code_loader
  import i281_code_loader_pkg::*;
#(
  parameter int WORDS = 16,
  parameter int AW    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  i281_code_loader_if.master   bus,
  output logic                 cpu_hold,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  state_t        state;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          csum_ok;
  logic          xfer;
  logic          last_word;
  logic          ck_clr;
  logic          ck_add;
  logic          ck_match;

  assign xfer      = bus.in_valid && bus.in_ready;
  assign last_word = (wr_addr == AW'(WORDS - 1));
  assign ck_clr    = (state == S_IDLE) && start;
  assign ck_add    = xfer && ((state == S_HI) || (state == S_LO));

  i281_byte_checksum u_csum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ck_clr),
    .add   (ck_add),
    .din   (bus.in_data),
    .cmp   (bus.in_data),
    .match (ck_match)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      wr_addr <= '0;
      wr_data <= '0;
      csum_ok <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state   <= S_HI;
          wr_addr <= '0;
          done    <= 1'b0;
          err     <= 1'b0;
        end
        S_HI: if (xfer) begin
          wr_data[15:8] <= bus.in_data;
          state         <= S_LO;
        end
        S_LO: if (xfer) begin
          wr_data[7:0] <= bus.in_data;
          state        <= S_WRITE;
        end
        S_WRITE: begin
          // Address stops at the last word; the checksum phase follows instead of a wrap.
          if (last_word) state <= S_CSUM;
          else begin
            wr_addr <= wr_addr + AW'(1);
            state   <= S_HI;
          end
        end
        S_CSUM: if (xfer) begin
          csum_ok <= ck_match;
          state   <= S_FIN;
        end
        S_FIN: begin
          done  <= csum_ok;
          err   <= !csum_ok;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready = (state == S_HI) || (state == S_LO) || (state == S_CSUM);
  assign bus.wr_en    = (state == S_WRITE);
  assign bus.wr_addr  = wr_addr;
  assign bus.wr_data  = wr_data;
  assign busy         = (state != S_IDLE);
  assign cpu_hold     = busy;

endmodule

// File: doc/i281_code_loader.md
I281_CODE_LOADER -- requirements
Module: i281_code_loader

Interface
REQ-001 Parameter: WORDS, default 16, number of 16-bit code-memory words loaded per session.
REQ-002 Parameter: AW, default 4, code-memory address width; WORDS SHALL equal 2**AW.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 start  in  1  one-cycle request to begin a load session.
REQ-006 in_data  in  8  byte from the host stream.
REQ-007 in_valid  in  1  in_data is valid this cycle.
REQ-008 in_ready  out  1  loader accepts in_data this cycle; a byte transfers when in_valid and in_ready are both 1.
REQ-009 wr_en  out  1  code-memory write strobe.
REQ-010 wr_addr  out  AW  code-memory write address.
REQ-011 wr_data  out  16  code-memory write word.
REQ-012 cpu_hold  out  1  holds the CPU (PC reset, fetch disabled) while loading.
REQ-013 busy  out  1  load session in progress.
REQ-014 done  out  1  last session completed with a matching checksum.
REQ-015 err  out  1  last session completed with a mismatched checksum.

Function
REQ-016 FSM states SHALL be IDLE, HI, LO, WRITE, CSUM and FIN.
REQ-017 IDLE: in_ready=0 and busy=0; start=1 SHALL go to HI, clear wr_addr, clear the checksum accumulator, and clear done and err.
REQ-018 HI: in_ready=1; an accepted byte SHALL latch to wr_data[15:8], add to the accumulator, and go to LO.
REQ-019 LO: in_ready=1; an accepted byte SHALL latch to wr_data[7:0], add to the accumulator, and go to WRITE.
REQ-020 WRITE: in_ready=0 and wr_en=1 for exactly one cycle, with wr_addr and wr_data stable; if wr_addr==WORDS-1 go to CSUM, else increment wr_addr and go to HI.
REQ-021 CSUM: in_ready=1; the accepted byte SHALL be compared with the 8-bit accumulator (sum of all 2*WORDS data bytes, mod 256), then go to FIN.
REQ-022 FIN: one cycle; set done=1 on a match or err=1 on a mismatch, then go to IDLE.
REQ-023 done and err SHALL hold until the next accepted start or reset, and SHALL never both be 1.
REQ-024 busy=1 and cpu_hold=1 in every state except IDLE.
REQ-025 start while busy=1 SHALL be ignored.
REQ-026 in_valid=0 in HI, LO or CSUM SHALL stall the FSM indefinitely with no state or accumulator change.
REQ-027 A byte presented in IDLE, WRITE or FIN SHALL not be consumed (in_ready=0).
REQ-028 wr_en SHALL never assert outside WRITE; exactly WORDS pulses per completed session, addresses 0..WORDS-1 in ascending order.
REQ-029 Throughput: at most one byte per cycle; a word takes at least 3 cycles (HI, LO, WRITE).
REQ-030 Accumulator SHALL be 8 bits and wrap modulo 256 with no overflow flag.
REQ-031 wr_addr SHALL not wrap within a session; the CSUM transition occurs instead.
REQ-032 Words already written by an aborted session (reset mid-load) SHALL remain in memory; the loader does not erase them.

Reset
REQ-033 rst_n=0 at a clock edge SHALL force state IDLE, wr_addr=0, wr_data=0, accumulator=0, and wr_en, in_ready, busy, cpu_hold, done and err all 0.
REQ-034 Reset asserted mid-session SHALL abort the session in the cycle it is sampled, with no further wr_en.

Structure
REQ-035 The FSM state enumeration and the byte-per-word constant (2) SHALL live in the shared i281 package; WORDS and AW stay module parameters.
REQ-036 One sub-module, i281_byte_checksum (8-bit clear/accumulate/compare), is natural; everything else is inline.

Verification
REQ-037 Bench: reset, start, 32 bytes forming the 16 words of the standard BIOS image (first word 0x5C10), correct checksum -> 16 wr_en pulses, addr 0..15 with matching data, done=1, err=0, cpu_hold low after FIN.
REQ-038 Bench: same stream with the checksum byte XOR 0x01 -> all 16 writes occur, then err=1, done=0.
REQ-039 Bench: random in_valid gaps of 0-5 cycles -> identical write sequence and result; no byte lost or duplicated.
REQ-040 Bench: rst_n=0 after the 7th word write -> next cycle IDLE, all outputs 0, no further wr_en; a subsequent full session succeeds.
REQ-041 Bench: start pulsed during LO and again during WRITE -> ignored; session completes normally.
REQ-042 Bench: all bytes 0xFF (sum 32*0xFF mod 256 = 0xE0), checksum 0xE0 -> done=1 (wrap-around check).
